// File: rtl/uart_pkg.sv
// Shared UART definitions: line encodings, TX state encoding and the baud divisor helper.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    BAUD_2400  = 2'b00,
    BAUD_4800  = 2'b01,
    BAUD_9600  = 2'b10,
    BAUD_19200 = 2'b11
  } baud_sel_t;

  // Encoding 2'b11 is deliberately left out and behaves as no parity.
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Clocks per bit; the clock must be fast enough that the result is at least 2.
  function automatic logic [15:0] baud_div(input int clk_hz, input logic [1:0] sel);
    int baud;
    case (sel)
      BAUD_2400: baud = 2400;
      BAUD_4800: baud = 4800;
      BAUD_9600: baud = 9600;
      default:   baud = 19200;
    endcase
    return 16'(clk_hz / baud);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Handshake, frame configuration and serial line shared between a UART TX user and the transmitter.
interface uart_tx_if;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       tx_start;
  logic [7:0] data_in;
  logic       tx_out;
  logic       busy;
  logic       done;

  modport master (
    output baud_rate, parity_type, stop_bits, tx_start, data_in,
    input  tx_out, busy, done
  );

  modport slave (
    input  baud_rate, parity_type, stop_bits, tx_start, data_in,
    output tx_out, busy, done
  );
endinterface

// File: rtl/baud_gen_tx.sv
// Loadable modulo-DIV counter; bit_tick marks the last clock of every bit period.
module baud_gen_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] div,
  output logic        bit_tick
);

  logic [15:0] cnt_q, cnt_d;

  assign bit_tick = (cnt_q == div - 16'd1);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (load || bit_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, LSB-first data, optional parity, one or two stop bits.
module uart_tx #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus
);
  import uart_pkg::*;

  localparam logic [2:0] S_IDLE   = TX_IDLE;
  localparam logic [2:0] S_START  = TX_START;
  localparam logic [2:0] S_DATA   = TX_DATA;
  localparam logic [2:0] S_PARITY = TX_PARITY;
  localparam logic [2:0] S_STOP   = TX_STOP;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        par_en_q, par_en_d;
  logic        par_bit_q, par_bit_d;
  logic        two_stop_q, two_stop_d;
  logic [15:0] div_q, div_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        load;
  logic        bit_tick;

  baud_gen_tx u_baud (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .div      (div_q),
    .bit_tick (bit_tick)
  );

  // Outputs are computed one cycle ahead so tx_out/busy/done come straight from flops.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    div_d      = div_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load       = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d   = IDLE_LEVEL;
        busy_d = 1'b0;
        if (bus.tx_start) begin
          data_d     = bus.data_in;
          two_stop_d = bus.stop_bits;
          div_d      = baud_div(CLK_HZ, bus.baud_rate);
          par_en_d   = 1'b0;
          par_bit_d  = 1'b0;
          if (bus.parity_type == PAR_ODD) begin
            par_en_d  = 1'b1;
            par_bit_d = ~^bus.data_in;
          end else if (bus.parity_type == PAR_EVEN) begin
            par_en_d  = 1'b1;
            par_bit_d = ^bus.data_in;
          end
          load    = 1'b1;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_tick) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          tx_d      = data_q[0];
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == LAST_BIT) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = S_STOP;
              stop_cnt_d = 1'b0;
              tx_d       = IDLE_LEVEL;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = data_q[bit_idx_q + 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
          tx_d       = IDLE_LEVEL;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = IDLE_LEVEL;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      div_q      <= '0;
      tx_q       <= IDLE_LEVEL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised scoreboard bench for uart_tx: stimulus queues expected frames, a line monitor decodes and compares them.
module tb_uart_tx;

  localparam int CLK_HZ = 96_000;

  typedef struct {
    logic [7:0]  data;
    int          div;
    int          nBits;
    logic [11:0] bits;
    logic        parEn;
    logic        parBit;
    int          nStop;
    bit          backToBack;
  } expFrame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_tx_if txIf ();

  expFrame_t expQ[$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int framesPushed = 0;
  int framesChecked = 0;
  int doneCount = 0;
  int lastDoneCycle = -100;
  bit monEnable = 1'b1;

  uart_tx #(.CLK_HZ(CLK_HZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (txIf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (monEnable && txIf.done === 1'b1) doneCount++;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference model: the frame as a list of line levels, one per bit period.
  function automatic expFrame_t buildFrame(input logic [7:0] data, input logic [1:0] baud,
                                           input logic [1:0] par, input logic stop, input bit b2b);
    expFrame_t f;
    int baudTable[4] = '{2400, 4800, 9600, 19200};
    int ones = 0;
    int pos;
    for (int i = 0; i < 8; i++) ones += int'(data[i]);
    f.data       = data;
    f.div        = CLK_HZ / baudTable[baud];
    f.parEn      = (par == 2'd1) || (par == 2'd2);
    f.parBit     = (par == 2'd1) ? (ones % 2 == 0) : (ones % 2 == 1);
    f.nStop      = stop ? 2 : 1;
    f.backToBack = b2b;
    f.bits       = '1;
    f.bits[0]    = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1 + i] = data[i];
    pos = 9;
    if (f.parEn) begin
      f.bits[pos] = f.parBit;
      pos++;
    end
    f.nBits = pos + f.nStop;
    return f;
  endfunction

  // Waits for the transmitter to be idle, then raises tx_start for the acceptance edge.
  // Returns at the first sample of the new frame with the expected frame length in clocks.
  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] baud, input logic [1:0] par,
                               input logic stop, input bit keepStart, input bit expectFrame,
                               output int frameLen);
    expFrame_t f;
    int w = 0;
    while (txIf.busy !== 1'b0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) checkOutput("idle_wait_timeout", 1, 0);
    f = buildFrame(data, baud, par, stop, 1'b0);
    frameLen = f.nBits * f.div;
    txIf.data_in     = data;
    txIf.baud_rate   = baud;
    txIf.parity_type = par;
    txIf.stop_bits   = stop;
    txIf.tx_start    = 1'b1;
    if (expectFrame) begin
      expQ.push_back(f);
      framesPushed++;
    end
    @(posedge clk);
    @(negedge clk);
    if (!keepStart) txIf.tx_start = 1'b0;
  endtask

  // Line monitor: decodes every frame at mid-bit and checks it cycle by cycle against the queue head.
  initial begin : monitor
    expFrame_t e;
    int n, lineErr, busyErr, doneErr;
    logic [11:0] rx;
    logic [7:0] rxData;
    forever begin
      @(negedge clk);
      if (monEnable && rst === 1'b1 && txIf.tx_out === 1'b0) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_frame", 1, 0);
          while (txIf.tx_out === 1'b0) @(negedge clk);
        end else begin
          e = expQ.pop_front();
          if (e.backToBack) checkOutput("b2b_gap", cycle - lastDoneCycle, 1);
          n = e.nBits * e.div;
          lineErr = 0;
          busyErr = 0;
          doneErr = 0;
          rx = '0;
          for (int s = 0; s < n; s++) begin
            if (s > 0) @(negedge clk);
            if (txIf.tx_out !== e.bits[s / e.div]) lineErr++;
            if (txIf.busy !== 1'b1) busyErr++;
            if (txIf.done !== 1'b0) doneErr++;
            if (s % e.div == e.div / 2) rx[s / e.div] = txIf.tx_out;
          end
          @(negedge clk);
          lastDoneCycle = cycle;
          checkOutput("line_waveform_errs", lineErr, 0);
          checkOutput("busy_in_frame_errs", busyErr, 0);
          checkOutput("done_in_frame_errs", doneErr, 0);
          checkOutput("done_at_end", int'(txIf.done), 1);
          checkOutput("busy_at_end", int'(txIf.busy), 0);
          checkOutput("line_high_at_end", int'(txIf.tx_out), 1);
          for (int i = 0; i < 8; i++) rxData[i] = rx[1 + i];
          checkOutput("rx_data", int'(rxData), int'(e.data));
          if (e.parEn) checkOutput("rx_parity", int'(rx[9]), int'(e.parBit));
          checkOutput("rx_stop", int'(rx[e.nBits - 1] & rx[e.nBits - e.nStop]), 1);
          framesChecked++;
        end
      end
    end
  end

  initial begin : stimulus
    int n, w, quietErr;
    txIf.data_in     = '0;
    txIf.baud_rate   = '0;
    txIf.parity_type = '0;
    txIf.stop_bits   = 1'b0;
    txIf.tx_start    = 1'b0;

    #2 rst = 1'b0;
    #1;
    checkOutput("reset_tx_out", int'(txIf.tx_out), 1);
    checkOutput("reset_busy", int'(txIf.busy), 0);
    checkOutput("reset_done", int'(txIf.done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Abort a 9600-baud frame in the middle of its data bits.
    monEnable = 1'b0;
    applyStimulus(8'hC3, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, n);
    repeat (25) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    checkOutput("midframe_reset_tx_out", int'(txIf.tx_out), 1);
    checkOutput("midframe_reset_busy", int'(txIf.busy), 0);
    checkOutput("midframe_reset_done", int'(txIf.done), 0);
    @(negedge clk);
    rst = 1'b1;
    quietErr = 0;
    repeat (30) begin
      @(negedge clk);
      if (txIf.tx_out !== 1'b1 || txIf.busy !== 1'b0 || txIf.done !== 1'b0) quietErr++;
    end
    checkOutput("post_reset_quiet_errs", quietErr, 0);
    monEnable = 1'b1;

    applyStimulus(8'hA5, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, n);
    applyStimulus(8'h07, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1, n);

    // Mid-frame config changes must not alter the captured frame.
    applyStimulus(8'h00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, n);
    repeat (100) @(negedge clk);
    txIf.baud_rate   = 2'b11;
    txIf.parity_type = 2'b00;
    txIf.stop_bits   = 1'b1;
    txIf.data_in     = 8'hFF;

    applyStimulus(8'h3C, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, n);
    repeat (50) @(negedge clk);
    txIf.data_in  = 8'h99;
    txIf.tx_start = 1'b1;
    @(negedge clk);
    txIf.tx_start = 1'b0;

    // Held tx_start: the second frame begins one clock after the done cycle.
    applyStimulus(8'h55, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, n);
    txIf.data_in = 8'hAA;
    expQ.push_back(buildFrame(8'hAA, 2'b10, 2'b00, 1'b0, 1'b1));
    framesPushed++;
    repeat (n + 1) @(negedge clk);
    txIf.tx_start = 1'b0;

    applyStimulus(8'h96, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, n);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'b0, 1'b1, n);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, n - 2)) @(negedge clk);
        txIf.data_in     = 8'($urandom);
        txIf.baud_rate   = 2'($urandom_range(0, 3));
        txIf.parity_type = 2'($urandom_range(0, 3));
        txIf.stop_bits   = 1'($urandom_range(0, 1));
        txIf.tx_start    = 1'b1;
        @(negedge clk);
        txIf.tx_start = 1'b0;
      end
    end

    w = 0;
    while (framesChecked != framesPushed && w < 3000) begin
      @(negedge clk);
      w++;
    end
    checkOutput("frames_checked", framesChecked, framesPushed);
    repeat (5) @(negedge clk);
    checkOutput("done_pulse_count", doneCount, framesPushed);
    checkOutput("final_idle_line", int'(txIf.tx_out), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
